inv_round_key_gen: RTL and testbench

INV_ROUND_KEY_GEN -- requirements
Module: inv_round_key_gen

---
 rtl/inv_round_key_gen.sv | 182 ++++++++++++++++++
 tb/tb_inv_round_key_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_key_gen.sv
// AES-128 inverse round-key generator: emits round keys 10 down to 0 with a valid/ready handshake.
// Define INV_KEY_FWD_EN to accept the cipher key and forward-expand it to round 10 first.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte, so index by the complement of a.
    assign c = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

module inv_round_key_gen (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] inkey,
    output logic [127:0] outkey,
    output logic [3:0]   rc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

`ifdef INV_KEY_FWD_EN
    typedef enum logic [1:0] {IDLE, EMIT, FIN, EXPAND} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
`endif

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     rc_q, rc_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    inv_w1, inv_w2, inv_w3;
    logic [31:0]    sbox_src, rot_word, sub_word, rcon_word;
    logic [3:0]     rcon_idx;
    logic [127:0]   inv_key;

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h01;
            4'd1:    b = 8'h02;
            4'd2:    b = 8'h04;
            4'd3:    b = 8'h08;
            4'd4:    b = 8'h10;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h40;
            4'd7:    b = 8'h80;
            4'd8:    b = 8'h1b;
            4'd9:    b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;

`ifdef INV_KEY_FWD_EN
    logic [31:0]  fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [127:0] fwd_key;

    // The forward step shares the S-boxes; it substitutes the unmodified w3 and
    // uses rc_q as the forward round counter while expanding.
    assign sbox_src = (state_q == EXPAND) ? w3 : inv_w3;
    assign rcon_idx = (state_q == EXPAND) ? rc_q : rc_q - 4'd1;

    assign fwd_w0  = w0 ^ sub_word ^ rcon_word;
    assign fwd_w1  = w1 ^ fwd_w0;
    assign fwd_w2  = w2 ^ fwd_w1;
    assign fwd_w3  = w3 ^ fwd_w2;
    assign fwd_key = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
`else
    assign sbox_src = inv_w3;
    assign rcon_idx = rc_q - 4'd1;
`endif

    assign rot_word  = {sbox_src[23:0], sbox_src[31:24]};
    assign rcon_word = rcon(rcon_idx);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .a (rot_word[8*i +: 8]),
            .c (sub_word[8*i +: 8])
        );
    end

    assign inv_key = {w0 ^ sub_word ^ rcon_word, inv_w1, inv_w2, inv_w3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d = inkey;
`ifdef INV_KEY_FWD_EN
                    state_d = EXPAND;
                    rc_d    = 4'd0;
`else
                    state_d = EMIT;
                    rc_d    = 4'd10;
`endif
                end
            end
`ifdef INV_KEY_FWD_EN
            EXPAND: begin
                key_d = fwd_key;
                rc_d  = rc_q + 4'd1;
                if (rc_q == 4'd9) begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                // Round 0 is the last key; hold it and finish rather than stepping below zero.
                if (out_ready) begin
                    if (rc_q == 4'd0) begin
                        state_d = FIN;
                    end else begin
                        key_d = inv_key;
                        rc_d  = rc_q - 4'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
        end
    end

    assign outkey    = key_q;
    assign rc        = rc_q;
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_inv_round_key_gen.sv
// Self-checking bench for inv_round_key_gen against a word-array AES key-schedule model.
// Honours INV_KEY_FWD_EN the same way as the design.

module tb_inv_round_key_gen;

    localparam logic [127:0] KEY_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KEY_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] inkey;
    logic [127:0] outkey;
    logic [3:0]   rc;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int compare_count = 0;
    int fail_count    = 0;
    int valid_cycles;
    int done_pulses;

    logic [7:0]   sbox_tab [0:255];
    logic [7:0]   rcon_tab [0:9];
    logic [127:0] exp_keys [0:10];
    logic [127:0] obs_keys [0:10];
    logic [127:0] seq_key;

    inv_round_key_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .inkey     (inkey),
        .outkey    (outkey),
        .rc        (rc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_tables();
        logic [7:0] inv_v;
        logic [7:0] r;
        for (int v = 0; v < 256; v++) begin
            inv_v = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(v), 8'(b)) == 8'h01) inv_v = 8'(b);
            end
            sbox_tab[v] = inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3) ^ rotl8(inv_v, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int i = 0; i < 10; i++) begin
            rcon_tab[i] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]], sbox_tab[w[31:24]]};
    endfunction

    task automatic build_model(input logic [127:0] k);
`ifdef INV_KEY_FWD_EN
        logic [31:0] ww [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) ww[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ww[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tab[i/4 - 1], 24'h000000};
            ww[i] = ww[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_keys[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
`else
        logic [31:0] w [0:3];
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        exp_keys[10] = k;
        for (int r = 10; r >= 1; r--) begin
            w[3] = w[3] ^ w[2];
            w[2] = w[2] ^ w[1];
            w[1] = w[1] ^ w[0];
            w[0] = w[0] ^ sub_rot(w[3]) ^ {rcon_tab[r-1], 24'h000000};
            exp_keys[r-1] = {w[0], w[1], w[2], w[3]};
        end
`endif
    endtask

    // Called at a falling edge; returns at the falling edge after start is accepted.
    task automatic apply_stimulus(input logic [127:0] k);
        check_output("idle_busy", 128'(busy), 128'(0));
        start = 1'b1;
        inkey = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes one sequence, checking every cycle against the phase/round model.
    // phase: 0 idle, 1 emitting, 2 finishing, 3 expanding.
    task automatic drain(input string tag, input bit rand_ready, input int stall_rc,
                         input int start_rc, input int abort_rc);
        int phase;
        int exp_rc;
        int expand_left;
        int stalled;
        bit start_done;
        bit aborted;
        bit hs;
        logic rdy;
`ifdef INV_KEY_FWD_EN
        phase = 3;
`else
        phase = 1;
`endif
        expand_left  = 10;
        exp_rc       = 10;
        stalled      = 0;
        start_done   = 1'b0;
        aborted      = 1'b0;
        valid_cycles = 0;
        done_pulses  = 0;
        for (int i = 0; i <= 10; i++) obs_keys[i] = '0;
        for (int cyc = 0; cyc < 200 && phase != 0; cyc++) begin
            check_output({tag, "_valid"}, 128'(out_valid), 128'(phase == 1));
            check_output({tag, "_busy"}, 128'(busy), 128'(1));
            check_output({tag, "_done"}, 128'(done), 128'(phase == 2));
            if (out_valid) valid_cycles++;
            if (done) done_pulses++;
            if (phase == 1) begin
                check_output({tag, "_rc"}, 128'(rc), 128'(exp_rc[3:0]));
                check_output({tag, "_key"}, outkey, exp_keys[exp_rc]);
            end
            start = 1'b0;
            if (phase == 1 && exp_rc == abort_rc) begin
                rst_n = 1'b0;
                #1;
                check_output({tag, "_abort_valid"}, 128'(out_valid), 128'(0));
                check_output({tag, "_abort_busy"}, 128'(busy), 128'(0));
                check_output({tag, "_abort_done"}, 128'(done), 128'(0));
                check_output({tag, "_abort_rc"}, 128'(rc), 128'(0));
                check_output({tag, "_abort_key"}, outkey, 128'(0));
                @(negedge clk);
                check_output({tag, "_held_busy"}, 128'(busy), 128'(0));
                rst_n     = 1'b1;
                out_ready = 1'b1;
                aborted   = 1'b1;
                break;
            end
            if (phase == 1 && exp_rc == start_rc && !start_done) begin
                start      = 1'b1;
                inkey      = {$urandom, $urandom, $urandom, $urandom};
                start_done = 1'b1;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (phase == 1 && exp_rc == stall_rc && stalled < 5) begin
                rdy = 1'b0;
                stalled++;
            end
            out_ready = rdy;
            hs = (phase == 1) && rdy;
            if (hs) obs_keys[exp_rc] = outkey;
            case (phase)
                1: if (hs) begin
                    if (exp_rc == 0) phase = 2;
                    else exp_rc--;
                end
                2: phase = 0;
                3: begin
                    expand_left--;
                    if (expand_left == 0) phase = 1;
                end
                default: phase = 0;
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        if (!aborted) check_output({tag, "_finished"}, 128'(phase), 128'(0));
    endtask

    initial begin
        logic [127:0] rkey;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        inkey     = '0;
        build_tables();
`ifdef INV_KEY_FWD_EN
        seq_key = KEY_R0;
`else
        seq_key = KEY_R10;
`endif
        #12;
        check_output("rst_outkey", outkey, 128'(0));
        check_output("rst_rc", 128'(rc), 128'(0));
        check_output("rst_valid", 128'(out_valid), 128'(0));
        check_output("rst_busy", 128'(busy), 128'(0));
        check_output("rst_done", 128'(done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] known vector, continuous ready");
        build_model(seq_key);
        out_ready = 1'b1;
        apply_stimulus(seq_key);
        drain("vec", 1'b0, -1, -1, -1);
        check_output("vec_valid_count", 128'(valid_cycles), 128'(11));
        check_output("vec_done_count", 128'(done_pulses), 128'(1));
        check_output("vec_round0", obs_keys[0], KEY_R0);
`ifdef INV_KEY_FWD_EN
        check_output("vec_round10", obs_keys[10], KEY_R10);
`else
        check_output("vec_round9", obs_keys[9], KEY_R9);
`endif

        $display("[TB] backpressure at round 7");
        apply_stimulus(seq_key);
        drain("stall", 1'b0, 7, -1, -1);
        check_output("stall_valid_count", 128'(valid_cycles), 128'(16));

        $display("[TB] start pulsed while busy");
        apply_stimulus(seq_key);
        drain("busy_start", 1'b0, -1, 5, -1);
        check_output("busy_start_round0", obs_keys[0], KEY_R0);

        $display("[TB] reset at round 4 then restart");
        apply_stimulus(seq_key);
        drain("abort", 1'b0, -1, -1, 4);
        apply_stimulus(seq_key);
        drain("restart", 1'b0, -1, -1, -1);
        check_output("restart_round0", obs_keys[0], KEY_R0);

        $display("[TB] random keys with random ready");
        for (int n = 0; n < 4; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            build_model(rkey);
            apply_stimulus(rkey);
            drain("rand", 1'b1, -1, -1, -1);
            check_output("rand_done_count", 128'(done_pulses), 128'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
